// File: rtl/pulse_qual.sv
// pulse_qual: glitch-rejecting level qualifier with edge strobes and pulse-width measurement (optional PULSE_QUAL_GLITCH_CNT_EN)
module pulse_qual #(
  parameter int MIN_WIDTH = 4,
  parameter int CNT_W     = 16,
  parameter int GCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic              dout,
  output logic              rise_p,
  output logic              fall_p,
  output logic [CNT_W-1:0]  width,
  output logic              width_vld,
  output logic [GCNT_W-1:0] glitch_cnt
);
  localparam int QW = $clog2(MIN_WIDTH + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(MIN_WIDTH - 1);
  typedef enum logic [1:0] {LO, QUAL_HI, HI, QUAL_LO} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, width_q, width_d;
  logic dout_q, dout_d, rise_q, rise_d, fall_q, fall_d, wvld_q, glitch_d;
  // qualification FSM: a new level must persist MIN_WIDTH synchronized samples
  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      LO: if (s2_q) begin
        if (MIN_WIDTH == 1) begin
          state_d = HI;
          rise_d  = 1'b1;
        end else begin
          state_d = QUAL_HI;
          qcnt_d  = QW'(1);
        end
      end
      QUAL_HI: if (!s2_q) begin
        state_d  = LO;
        qcnt_d   = '0;
        glitch_d = 1'b1;
      end else if (qcnt_q == Q_LAST) begin
        state_d = HI;
        qcnt_d  = '0;
        rise_d  = 1'b1;
      end else qcnt_d = qcnt_q + QW'(1);
      HI: if (!s2_q) begin
        if (MIN_WIDTH == 1) begin
          state_d = LO;
          fall_d  = 1'b1;
        end else begin
          state_d = QUAL_LO;
          qcnt_d  = QW'(1);
        end
      end
      QUAL_LO: if (s2_q) begin
        state_d  = HI;
        qcnt_d   = '0;
        glitch_d = 1'b1;
      end else if (qcnt_q == Q_LAST) begin
        state_d = LO;
        qcnt_d  = '0;
        fall_d  = 1'b1;
      end else qcnt_d = qcnt_q + QW'(1);
      default: state_d = LO;
    endcase
    dout_d  = (state_d == HI) || (state_d == QUAL_LO);
    hcnt_d  = rise_d ? CNT_W'(1) : (dout_q && !fall_d && hcnt_q != '1) ? hcnt_q + CNT_W'(1) : hcnt_q;
    width_d = fall_d ? hcnt_q : width_q;
  end
  // synchronizer, state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LO;
      qcnt_q  <= '0;
      hcnt_q  <= '0;
      width_q <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      wvld_q  <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      hcnt_q  <= hcnt_d;
      width_q <= width_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      wvld_q  <= fall_d;
    end
  end
  assign dout      = dout_q;
  assign rise_p    = rise_q;
  assign fall_p    = fall_q;
  assign width_vld = wvld_q;
  assign width     = width_q;
`ifdef PULSE_QUAL_GLITCH_CNT_EN
  logic [GCNT_W-1:0] gcnt_q;
  // saturating count of rejected excursions
  always_ff @(posedge clk) begin
    if (!rst_n) gcnt_q <= '0;
    else if (glitch_d && gcnt_q != '1) gcnt_q <= gcnt_q + GCNT_W'(1);
  end
  assign glitch_cnt = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_d;
  assign glitch_cnt    = '0;
`endif
endmodule
